// File: rtl/instr_aligner.sv
// instr_aligner
// Sits between the instruction fetch bus and decode. It keeps a halfword FIFO
// filled from FETCH_W-bit fetch words and joins 32-bit instructions that
// straddle two fetch words. Compressed (16-bit) instructions are expanded to
// their 32-bit form. It emits one instruction per valid/ready handshake,
// together with its PC.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   in_flush, in_flush_pc        redirect pulse and halfword-aligned target
//   in_fw_vld/out_fw_rdy         fetch word handshake
//   in_fw_data, in_fw_pc         fetch word (little-endian halfwords) and its address
//   out_ir_vld/in_ir_rdy         instruction handshake toward decode
//   out_ir, out_cif, out_pc      expanded instruction, 16-bit source flag, its PC
module instr_aligner #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_flush,
  input  logic [31:0]        in_flush_pc,
  input  logic               in_fw_vld,
  output logic               out_fw_rdy,
  input  logic [FETCH_W-1:0] in_fw_data,
  input  logic [31:0]        in_fw_pc,
  output logic               out_ir_vld,
  input  logic               in_ir_rdy,
  output logic [31:0]        out_ir,
  output logic               out_cif,
  output logic [31:0]        out_pc
);

  localparam int unsigned NHW   = FETCH_W / 16;
  localparam int unsigned BYTES = FETCH_W / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned SKW   = OFFW - 1;
  localparam int unsigned PW    = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int unsigned CW    = $clog2(BUF_HW + 1);

  localparam logic [31:0] ILLEGAL_INSTR = 32'h0000_0000;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_OP   = 7'b0110011;
  localparam logic [6:0]  OP_LD   = 7'b0000011;
  localparam logic [6:0]  OP_ST   = 7'b0100011;
  localparam logic [6:0]  OP_LUI  = 7'b0110111;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_BR   = 7'b1100011;

  // Pointer increment modulo BUF_HW (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [31:0] k);
    logic [31:0] s;
    s = 32'(p) + k;
    if (s >= BUF_HW) s = s - BUF_HW;
    else             s = s;
    return s[PW-1:0];
  endfunction

  // RV32C to RV32I expansion; reserved or unsupported encodings give ILLEGAL_INSTR.
  function automatic logic [31:0] rvc_expand(input logic [15:0] c);
    logic [31:0] r;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6;
    logic [20:1] jimm;
    logic [12:1] bimm;
    r    = ILLEGAL_INSTR;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    jimm = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    bimm = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
    case ({c[15:13], c[1:0]})
      5'b000_00: if (c[12:5] != 8'h00)   // c.addi4spn
                   r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
                 else r = ILLEGAL_INSTR;
      5'b010_00: r = {5'b00000, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OP_LD};
      5'b110_00: r = {5'b00000, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OP_ST};
      5'b000_01: r = {imm6, rd, 3'b000, rd, OP_IMM};                               // c.addi / c.nop
      5'b001_01: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, OP_JAL};  // c.jal
      5'b010_01: r = {imm6, 5'd0, 3'b000, rd, OP_IMM};                             // c.li
      5'b011_01: if ({c[12], c[6:2]} == 6'd0) r = ILLEGAL_INSTR;
                 else if (rd == 5'd2)         // c.addi16sp
                   r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
                 else r = {{15{c[12]}}, c[6:2], rd, OP_LUI};                       // c.lui
      5'b100_01: case (c[11:10])
                   2'b00: if (c[12]) r = ILLEGAL_INSTR;
                          else r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                   2'b01: if (c[12]) r = ILLEGAL_INSTR;
                          else r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                   2'b10: r = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
                   2'b11: if (c[12]) r = ILLEGAL_INSTR;
                          else case (c[6:5])
                            2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP};
                            2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP};
                            2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP};
                            2'b11:   r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP};
                            default: r = ILLEGAL_INSTR;
                          endcase
                   default: r = ILLEGAL_INSTR;
                 endcase
      5'b101_01: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, OP_JAL};   // c.j
      5'b110_01: r = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], OP_BR};
      5'b111_01: r = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], OP_BR};
      5'b000_10: if (c[12]) r = ILLEGAL_INSTR;
                 else r = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};            // c.slli
      5'b010_10: if (rd == 5'd0) r = ILLEGAL_INSTR;
                 else r = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LD};
      5'b100_10: if (!c[12]) begin
                   if (rs2 != 5'd0)     r = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_OP};  // c.mv
                   else if (rd != 5'd0) r = {12'h000, rd, 3'b000, 5'd0, OP_JALR};        // c.jr
                   else                 r = ILLEGAL_INSTR;
                 end else begin
                   if (rs2 != 5'd0)     r = {7'b0000000, rs2, rd, 3'b000, rd, OP_OP};    // c.add
                   else if (rd != 5'd0) r = {12'h000, rd, 3'b000, 5'd1, OP_JALR};        // c.jalr
                   else                 r = 32'h0010_0073;                               // c.ebreak
                 end
      5'b110_10: r = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OP_ST};
      default:   r = ILLEGAL_INSTR;
    endcase
    return r;
  endfunction

  logic [15:0]    buf_r [BUF_HW];
  logic [PW-1:0]  head_r, tail_r;
  logic [CW-1:0]  cnt_r;
  logic [31:0]    head_pc_r, exp_fw_pc_r;
  logic [SKW-1:0] skip_r;

  logic        fw_rdy_s, is16_s, ir_vld_s, pop_s, push_s;
  logic [15:0] head_hw_s, next_hw_s;
  logic [31:0] pop_n_s, push_n_s;
  logic        unused_s;

  assign unused_s = in_flush_pc[0];

  // Handshake decisions and halfword counts from registered state.
  always_comb begin
    fw_rdy_s  = ((32'(cnt_r) + NHW) <= BUF_HW);
    head_hw_s = buf_r[head_r];
    next_hw_s = buf_r[ptr_add(head_r, 32'd1)];
    is16_s    = (head_hw_s[1:0] != 2'b11);
    ir_vld_s  = !in_flush && ((cnt_r >= CW'(1) && is16_s) || (cnt_r >= CW'(2) && !is16_s));
    pop_s     = ir_vld_s && in_ir_rdy;
    pop_n_s   = pop_s ? (is16_s ? 32'd1 : 32'd2) : 32'd0;
    // A word at the wrong address is stale: it is consumed but never pushed.
    push_s    = in_fw_vld && fw_rdy_s && !in_flush && (in_fw_pc == exp_fw_pc_r);
    push_n_s  = push_s ? (NHW - 32'(skip_r)) : 32'd0;
  end

  assign out_fw_rdy = fw_rdy_s;
  assign out_ir_vld = ir_vld_s;
  assign out_cif    = is16_s;
  assign out_pc     = head_pc_r;
  assign out_ir     = is16_s ? rvc_expand(head_hw_s) : {next_hw_s, head_hw_s};

  // FIFO, pointers, PCs and skip; a flush overrides any push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r      <= '0;
      tail_r      <= '0;
      cnt_r       <= '0;
      head_pc_r   <= RESET_PC;
      exp_fw_pc_r <= {RESET_PC[31:OFFW], {OFFW{1'b0}}};
      skip_r      <= RESET_PC[OFFW-1:1];
      for (int i = 0; i < int'(BUF_HW); i++) buf_r[i] <= 16'h0000;
    end else if (in_flush) begin
      head_r      <= '0;
      tail_r      <= '0;
      cnt_r       <= '0;
      head_pc_r   <= {in_flush_pc[31:1], 1'b0};
      exp_fw_pc_r <= {in_flush_pc[31:OFFW], {OFFW{1'b0}}};
      skip_r      <= in_flush_pc[OFFW-1:1];
    end else begin
      if (push_s) begin
        // Halfwords below the redirect target's offset are dropped.
        for (int i = 0; i < int'(NHW); i++) begin
          if (32'(i) >= 32'(skip_r))
            buf_r[ptr_add(tail_r, 32'(i) - 32'(skip_r))] <= in_fw_data[16*i +: 16];
        end
        tail_r      <= ptr_add(tail_r, push_n_s);
        skip_r      <= '0;
        exp_fw_pc_r <= exp_fw_pc_r + 32'(BYTES);
      end
      if (pop_s) begin
        head_r    <= ptr_add(head_r, pop_n_s);
        head_pc_r <= head_pc_r + (is16_s ? 32'd2 : 32'd4);
      end
      cnt_r <= CW'(32'(cnt_r) + push_n_s - pop_n_s);
    end
  end

endmodule
